pe_tap_sequencer: RTL

Drives a single `PE` through a TAPS-long multiply-accumulate window and returns the finished partial sum on a valid/ready result port. It sits between the pixel/weight streams and one PE instance:
- It generates `PE_Out_Reg_Set`, `PE_Fifo_Set`, `PE_Is`, `PE_If_Px` and `PE_w`.
- It consumes `PE_Out` as the accumulator feedback.

Weights are loaded once and kept. Pixels are streamed one per tap.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/pe_weight_file.sv | 54 +++++
 rtl/pe_tap_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN processing-element datapath blocks:
// default widths, default kernel size and the tap-sequencer state encoding.
package cnn_pkg;

    localparam int PX_WIDTH_DEF       = 9;
    localparam int W_WIDTH_DEF        = 9;
    localparam int DATA_OUT_WIDTH_DEF = 9;
    localparam int TAPS_DEF           = 9;
    localparam int CNT_WIDTH_DEF      = 4;

    localparam logic [1:0] S_LOAD_ENC = 2'd0;
    localparam logic [1:0] S_RUN_ENC  = 2'd1;
    localparam logic [1:0] S_CAP_ENC  = 2'd2;
    localparam logic [1:0] S_HOLD_ENC = 2'd3;

    typedef enum logic [1:0] {
        S_LOAD = S_LOAD_ENC,
        S_RUN  = S_RUN_ENC,
        S_CAP  = S_CAP_ENC,
        S_HOLD = S_HOLD_ENC
    } pseq_state_e;

endpackage

// File: rtl/pe_weight_file.sv
// Small weight register file: one write port, one combinational read port,
// asynchronously cleared to zero. Index decode is done by comparison so the
// index width does not have to match the depth exactly.
module pe_weight_file #(
    parameter int DEPTH     = 9,
    parameter int W_WIDTH   = 9,
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [IDX_WIDTH-1:0] widx,
    input  logic [W_WIDTH-1:0]   wdata,
    input  logic [IDX_WIDTH-1:0] ridx,
    output logic [W_WIDTH-1:0]   rdata
);

    logic [W_WIDTH-1:0] mem_q [DEPTH];
    logic [W_WIDTH-1:0] mem_d [DEPTH];

    // Next-state of the array: the addressed entry takes the write data
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (we && (widx == IDX_WIDTH'(i))) begin
                mem_d[i] = wdata;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Weight storage, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read; out-of-range index reads as zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ridx == IDX_WIDTH'(i)) begin
                rdata = mem_q[i];
            end else begin
                rdata = rdata;
            end
        end
    end

endmodule

// File: rtl/pe_tap_sequencer.sv
// Steps one PE through a TAPS-long multiply-accumulate window. Weights are
// loaded once and retained; pixels stream one per tap. The PE registers on
// the same edge that accepts a pixel, and the finished partial sum is held
// on a valid/ready result port until taken.
module pe_tap_sequencer
    import cnn_pkg::*;
#(
    parameter int PX_WIDTH       = PX_WIDTH_DEF,
    parameter int W_WIDTH        = W_WIDTH_DEF,
    parameter int DATA_OUT_WIDTH = DATA_OUT_WIDTH_DEF,
    parameter int TAPS           = TAPS_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic                      PSEQ_Clk,
    input  logic                      PSEQ_Reset,
    input  logic                      PSEQ_W_Load,
    input  logic [W_WIDTH-1:0]        PSEQ_W_In,
    input  logic [DATA_OUT_WIDTH-1:0] PSEQ_Bias,
    input  logic                      PSEQ_Px_Valid,
    input  logic [PX_WIDTH-1:0]       PSEQ_Px_In,
    output logic                      PSEQ_Px_Ready,
    output logic                      PSEQ_Pe_Out_Reg_Set,
    output logic                      PSEQ_Pe_Fifo_Set,
    output logic [DATA_OUT_WIDTH-1:0] PSEQ_Pe_Is,
    output logic [PX_WIDTH-1:0]       PSEQ_Pe_If_Px,
    output logic [W_WIDTH-1:0]        PSEQ_Pe_W,
    input  logic [DATA_OUT_WIDTH-1:0] PSEQ_Pe_Out,
    output logic                      PSEQ_Res_Valid,
    output logic [DATA_OUT_WIDTH-1:0] PSEQ_Res_Data,
    input  logic                      PSEQ_Res_Ready,
    output logic                      PSEQ_Busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TAPS - 1);

    pseq_state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0]      tap_q, tap_d;
    logic [CNT_WIDTH-1:0]      ld_cnt_q, ld_cnt_d;
    logic [DATA_OUT_WIDTH-1:0] res_data_q, res_data_d;

    logic                 px_ready_s;
    logic                 accept_s;
    logic                 tap_zero_s;
    logic                 tap_last_s;
    logic                 wf_we_s;
    logic [CNT_WIDTH-1:0] wf_widx_s;
    logic [W_WIDTH-1:0]   wf_rdata_s;

    assign px_ready_s = (state_q == S_RUN);
    assign accept_s   = px_ready_s & PSEQ_Px_Valid;
    assign tap_zero_s = (tap_q == CNT_ZERO);
    assign tap_last_s = (tap_q == CNT_LAST);

    pe_weight_file #(
        .DEPTH     (TAPS),
        .W_WIDTH   (W_WIDTH),
        .IDX_WIDTH (CNT_WIDTH)
    ) u_weight_file (
        .clk   (PSEQ_Clk),
        .rst_n (PSEQ_Reset),
        .we    (wf_we_s),
        .widx  (wf_widx_s),
        .wdata (PSEQ_W_In),
        .ridx  (tap_q),
        .rdata (wf_rdata_s)
    );

    // Next-state, counters, weight write and result capture
    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        ld_cnt_d   = ld_cnt_q;
        res_data_d = res_data_q;
        wf_we_s    = 1'b0;
        wf_widx_s  = ld_cnt_q;
        case (state_q)
            S_LOAD: begin
                if (PSEQ_W_Load) begin
                    wf_we_s = 1'b1;
                    if (ld_cnt_q == CNT_LAST) begin
                        state_d  = S_RUN;
                        tap_d    = CNT_ZERO;
                        ld_cnt_d = CNT_ZERO;
                    end else begin
                        ld_cnt_d = ld_cnt_q + CNT_ONE;
                    end
                end else begin
                    ld_cnt_d = ld_cnt_q;
                end
            end
            S_RUN: begin
                if (accept_s) begin
                    if (tap_last_s) begin
                        state_d = S_CAP;
                    end else begin
                        tap_d = tap_q + CNT_ONE;
                    end
                end else if (PSEQ_W_Load && tap_zero_s) begin
                    // Reload between windows: this strobe is weight 0
                    wf_we_s   = 1'b1;
                    wf_widx_s = CNT_ZERO;
                    ld_cnt_d  = CNT_ONE;
                    state_d   = S_LOAD;
                end else begin
                    tap_d = tap_q;
                end
            end
            S_CAP: begin
                res_data_d = PSEQ_Pe_Out;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (PSEQ_Res_Ready) begin
                    state_d = S_RUN;
                    tap_d   = CNT_ZERO;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d  = S_LOAD;
                tap_d    = CNT_ZERO;
                ld_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // Sequencer state registers; reset discards any partial window
    always_ff @(posedge PSEQ_Clk or negedge PSEQ_Reset) begin
        if (!PSEQ_Reset) begin
            state_q    <= S_LOAD;
            tap_q      <= CNT_ZERO;
            ld_cnt_q   <= CNT_ZERO;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            ld_cnt_q   <= ld_cnt_d;
            res_data_q <= res_data_d;
        end
    end

    // PE drive is combinational so the PE updates on the accepting edge
    assign PSEQ_Px_Ready       = px_ready_s;
    assign PSEQ_Pe_If_Px       = PSEQ_Px_In;
    assign PSEQ_Pe_W           = wf_rdata_s;
    assign PSEQ_Pe_Is          = tap_zero_s ? PSEQ_Bias : PSEQ_Pe_Out;
    assign PSEQ_Pe_Out_Reg_Set = accept_s;
    assign PSEQ_Pe_Fifo_Set    = accept_s & tap_last_s;
    assign PSEQ_Res_Valid      = (state_q == S_HOLD);
    assign PSEQ_Res_Data       = res_data_q;
    assign PSEQ_Busy           = ((state_q == S_RUN) && !tap_zero_s) ||
                                 (state_q == S_CAP) || (state_q == S_HOLD);

endmodule
